// File: rtl/div4bit_asmd.sv
// div4bit_asmd: sequential restoring divider (ASMD controller + shift/subtract
// datapath). Produces one quotient bit per clock and reports the result with a
// one-cycle done pulse, mirroring the shift-add multiplier's start/finish
// handshake.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        request strobe, sampled only in IDLE
//   dividend     N-bit unsigned dividend, sampled with start
//   divisor      N-bit unsigned divisor, sampled with start
//   quotient     registered N-bit quotient, valid from done onward
//   remainder    registered N-bit remainder, valid from done onward
//   busy         high from the accepting edge through the done cycle
//   done         one-cycle completion pulse
//   div_by_zero  error flag for the current result, valid with done
module div4bit_asmd #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          skip_q, skip_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dz_q, dz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // One restoring step: N+1 bit partial remainder so the shift never overflows.
  logic [N:0]    shifted;
  logic [N:0]    trial;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      skip_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    skip_d  = skip_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    shifted = {r_q, q_q[N-1]};
    trial   = shifted - {1'b0, d_q};

    case (state_q)
      S_COMPUTE: begin
        if (skip_q) begin
          // Divide-by-zero: result already published, spend one cycle here so
          // done lands one cycle after the accepting edge.
          state_d = S_DONE;
        end else begin
          if (!trial[N]) begin
            r_d = trial[N-1:0];
            q_d = {q_q[N-2:0], 1'b1};
          end else begin
            r_d = shifted[N-1:0];
            q_d = {q_q[N-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            quot_d  = q_d;
            rem_d   = r_d;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        // IDLE, and the unused encoding 3 which behaves as IDLE.
        state_d = S_IDLE;
        if (start) begin
          state_d = S_COMPUTE;
          if (divisor != '0) begin
            q_d    = dividend;
            d_d    = divisor;
            r_d    = '0;
            cnt_d  = '0;
            dz_d   = 1'b0;
            skip_d = 1'b0;
          end else begin
            quot_d = '1;
            rem_d  = dividend;
            dz_d   = 1'b1;
            skip_d = 1'b1;
          end
        end
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_div4bit_asmd.sv
// Scoreboard bench for div4bit_asmd: the stimulus process pushes expected
// results (with the cycle their done pulse must appear) and the monitor
// compares them whenever done is seen.
module tb_div4bit_asmd;

  localparam int unsigned N  = 4;
  localparam int unsigned N8 = 8;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [N-1:0]  dividend, divisor, quotient, remainder;
  logic          busy, done, div_by_zero;
  logic          start8;
  logic [N8-1:0] dividend8, divisor8, quotient8, remainder8;
  logic          busy8, done8, div_by_zero8;

  always #5 clk = ~clk;

  div4bit_asmd #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend),
    .divisor(divisor), .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  div4bit_asmd #(.N(N8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .dividend(dividend8),
    .divisor(divisor8), .quotient(quotient8), .remainder(remainder8),
    .busy(busy8), .done(done8), .div_by_zero(div_by_zero8)
  );

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int acc;
    int done_cyc;
    int a;
    int b;
    int q;
    int r;
    int dz;
  } exp_t;

  typedef struct {
    int cyc;
    int q;
    int r;
    int busy;
    int done;
    int dz;
  } snap_t;

  exp_t  exp_q[$];
  exp_t  exp8_q[$];
  snap_t snap_q[$];
  bit    end_req = 1'b0;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: all comparisons happen here, away from the rising edge.
  initial begin
    exp_t  e;
    snap_t s;
    forever begin
      @(negedge clk);
      while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
        s = snap_q.pop_front();
        if (s.cyc < cyc) begin
          chk("snapshot_missed", cyc, s.cyc);
        end else begin
          chk("snap_quotient", int'(quotient), s.q);
          chk("snap_remainder", int'(remainder), s.r);
          chk("snap_busy", int'(busy), s.busy);
          chk("snap_done", int'(done), s.done);
          chk("snap_div_by_zero", int'(div_by_zero), s.dz);
        end
      end
      if (exp_q.size() > 0 && cyc >= exp_q[0].acc && cyc <= exp_q[0].done_cyc)
        chk("busy_in_op", int'(busy), 1);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("quotient", int'(quotient), e.q);
          chk("remainder", int'(remainder), e.r);
          chk("div_by_zero", int'(div_by_zero), e.dz);
          if (e.dz == 0)
            chk("invariant", int'(quotient) * e.b + int'(remainder), e.a);
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].done_cyc) begin
        e = exp_q.pop_front();
        chk("done_missing", cyc, e.done_cyc);
      end
      if (done8) begin
        if (exp8_q.size() == 0) begin
          chk("spurious_done8", 1, 0);
        end else begin
          e = exp8_q.pop_front();
          chk("done8_cycle", cyc, e.done_cyc);
          chk("quotient8", int'(quotient8), e.q);
          chk("remainder8", int'(remainder8), e.r);
          chk("div_by_zero8", int'(div_by_zero8), e.dz);
        end
      end else if (exp8_q.size() > 0 && cyc > exp8_q[0].done_cyc) begin
        e = exp8_q.pop_front();
        chk("done8_missing", cyc, e.done_cyc);
      end
      if (end_req) begin
        chk("leftover_expectations", exp_q.size() + exp8_q.size() + snap_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_snap(input int c, input int q, input int r,
                           input int b, input int d, input int z);
    snap_q.push_back('{cyc: c, q: q, r: r, busy: b, done: d, dz: z});
  endtask

  // Issue one 4-bit operation; returns its accepting edge and done cycle.
  task automatic issue(input int a, input int b, input int q, input int r,
                       input int z, output int e0, output int dc);
    dividend = N'(a);
    divisor  = N'(b);
    start    = 1'b1;
    e0 = cyc + 1;
    dc = (b == 0) ? e0 + 1 : e0 + int'(N);
    exp_q.push_back('{acc: e0, done_cyc: dc, a: a, b: b, q: q, r: r, dz: z});
    tick();
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
  endtask

  initial begin
    int e0, dc;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    start8 = 1'b0; dividend8 = '0; divisor8 = '0;
    push_snap(2, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;

    // 13/3 -> 4 r 1, then outputs hold with busy low.
    issue(13, 3, 4, 1, 0, e0, dc);
    push_snap(dc + 1, 4, 1, 0, 0, 0);
    wait_until(dc + 1);

    // Back-to-back on the first legal cycle.
    issue(15, 1, 15, 0, 0, e0, dc);
    wait_until(dc + 1);
    issue(2, 7, 0, 2, 0, e0, dc);
    wait_until(dc + 1);

    // Divide by zero, then a normal op clears only the flag at accept.
    issue(9, 0, 15, 9, 1, e0, dc);
    wait_until(dc + 1);
    push_snap(cyc + 1, 15, 9, 1, 0, 0);
    issue(6, 2, 3, 0, 0, e0, dc);
    wait_until(dc + 1);

    // Start pulses mid-op and in the done cycle are ignored.
    issue(14, 3, 4, 2, 0, e0, dc);
    wait_until(e0 + 1);
    start = 1'b1; dividend = 4'd7; divisor = 4'd7;
    tick();
    start = 1'b0;
    wait_until(dc);
    start = 1'b1; dividend = 4'd7; divisor = 4'd7;
    tick();
    start = 1'b0;
    wait_until(cyc + 8);

    // Reset mid-computation: everything clears, no done pulse.
    dividend = 4'd11; divisor = 4'd2; start = 1'b1;
    e0 = cyc + 1;
    tick();
    start = 1'b0;
    wait_until(e0 + 1);
    reset = 1'b1;
    push_snap(e0 + 2, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    wait_until(cyc + 8);
    issue(11, 2, 5, 1, 0, e0, dc);
    wait_until(dc + 1);

    // Full 4-bit sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(a, b, (b == 0) ? 15 : a / b, (b == 0) ? a : a % b,
              (b == 0) ? 1 : 0, e0, dc);
        wait_until(dc + 1);
      end
    end

    // Eight-bit instance: 200/7 -> 28 r 4.
    dividend8 = 8'd200; divisor8 = 8'd7; start8 = 1'b1;
    e0 = cyc + 1;
    exp8_q.push_back('{acc: e0, done_cyc: e0 + int'(N8), a: 200, b: 7,
                       q: 28, r: 4, dz: 0});
    tick();
    start8 = 1'b0; dividend8 = '0; divisor8 = '0;
    wait_until(e0 + int'(N8) + 3);

    end_req = 1'b1;
    repeat (5) tick();
    $display("FAIL end_of_test: monitor did not close the run");
    $fatal(1);
  end

endmodule
